// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and sequencing controller for the five-stage pipeline.
// Produces IF/ID stall and flush, an ID/EX bubble request and PC hold for
// load-use stalls, taken-branch flushes and the multi-cycle RET sequence.
// Also keeps a saturating count of stalled cycles and a sticky RET timeout flag.
//
// Handshake note: ret_pc_valid is a one-cycle strobe from MEM. It is only
// consumed while in RET_WAIT; the controller is always ready for it there,
// and the strobe is ignored in RUN.
module pipeline_hazard_ctrl #(
   parameter int REG_ADDR_W   = 3,
   parameter int RET_MAX_WAIT = 4,
   parameter int CNT_W        = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [REG_ADDR_W-1:0] id_rsrc,
   input  logic [REG_ADDR_W-1:0] id_rdst,
   input  logic                  id_use_rsrc,
   input  logic                  id_use_rdst,
   input  logic                  id_is_ret,
   input  logic                  ex_mem_read,
   input  logic [REG_ADDR_W-1:0] ex_rdst,
   input  logic                  ex_branch_taken,
   input  logic                  ret_pc_valid,
   output logic                  IF_Stall,
   output logic                  IF_Flush,
   output logic                  id_bubble,
   output logic                  pc_hold,
   output logic                  ret_timeout,
   output logic [CNT_W-1:0]      stall_count,
   output logic                  dbg_state
);

   typedef enum logic {
      ST_RUN      = 1'b0,
      ST_RET_WAIT = 1'b1
   } state_t;

   localparam int WAIT_W = $clog2(RET_MAX_WAIT + 1);
   localparam logic [WAIT_W-1:0] WAIT_MAX    = WAIT_W'(RET_MAX_WAIT);
   localparam logic [WAIT_W-1:0] WAIT_MAX_M1 = WAIT_W'(RET_MAX_WAIT - 1);
   localparam logic [WAIT_W-1:0] WAIT_ONE    = WAIT_W'(1);
   localparam logic [CNT_W-1:0]  CNT_ONE     = CNT_W'(1);

   state_t            state;
   logic [WAIT_W-1:0] wait_cnt;
   logic              lu;

   // Load in EX writes a register the instruction in ID actually reads (R0 included).
   assign lu = ex_mem_read &
               ((id_use_rsrc & (id_rsrc == ex_rdst)) |
                (id_use_rdst & (id_rdst == ex_rdst)));

   assign dbg_state = state;

   // Control outputs decoded from state and current inputs; all zero during reset.
   always_comb begin
      IF_Stall  = 1'b0;
      IF_Flush  = 1'b0;
      id_bubble = 1'b0;
      pc_hold   = 1'b0;
      if (!rst) begin
         case (state)
            ST_RUN: begin
               if (ex_branch_taken) begin
                  // The ID instruction is squashed, so its hazards do not matter.
                  IF_Flush  = 1'b1;
                  id_bubble = 1'b1;
               end else if (lu) begin
                  IF_Stall  = 1'b1;
                  pc_hold   = 1'b1;
                  id_bubble = 1'b1;
               end else if (id_is_ret) begin
                  // RET proceeds to EX; the fetch behind it is discarded.
                  IF_Flush = 1'b1;
                  pc_hold  = 1'b1;
               end
            end
            ST_RET_WAIT: begin
               IF_Flush = 1'b1;
               pc_hold  = ~ret_pc_valid;
            end
            default: begin
               IF_Flush = 1'b0;
            end
         endcase
      end
   end

   // RET sequencing state, wait counter and sticky timeout flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= ST_RUN;
         wait_cnt    <= '0;
         ret_timeout <= 1'b0;
      end else begin
         case (state)
            ST_RUN: begin
               if (!ex_branch_taken && !lu && id_is_ret) begin
                  state    <= ST_RET_WAIT;
                  wait_cnt <= '0;
               end
            end
            ST_RET_WAIT: begin
               if (ret_pc_valid) begin
                  state <= ST_RUN;
               end else begin
                  if (wait_cnt < WAIT_MAX) begin
                     wait_cnt <= wait_cnt + WAIT_ONE;
                  end
                  // Flag goes up on the edge where wait_cnt arrives at the limit.
                  if (wait_cnt >= WAIT_MAX_M1) begin
                     ret_timeout <= 1'b1;
                  end
               end
            end
            default: begin
               state <= ST_RUN;
            end
         endcase
      end
   end

   // Saturating count of cycles spent with IF_Stall asserted.
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_count <= '0;
      end else if (IF_Stall && (stall_count != {CNT_W{1'b1}})) begin
         stall_count <= stall_count + CNT_ONE;
      end
   end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed vector table,
// hand-written RET/timeout/saturation sequences and randomized stimulus
// against a behavioural reference model.
module tb_pipeline_hazard_ctrl;

   localparam int RW   = 3;
   localparam int MAXW = 4;
   localparam int CW   = 16;
   localparam int CMAX = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          rst;
   logic [RW-1:0] id_rsrc, id_rdst, ex_rdst;
   logic          id_use_rsrc, id_use_rdst, id_is_ret, ex_mem_read;
   logic          ex_branch_taken, ret_pc_valid;
   logic          IF_Stall, IF_Flush, id_bubble, pc_hold, ret_timeout, dbg_state;
   logic [CW-1:0] stall_count;

   // Clock and DUT
   always #5 clk = ~clk;

   pipeline_hazard_ctrl #(.REG_ADDR_W(RW), .RET_MAX_WAIT(MAXW), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst),
      .id_rsrc(id_rsrc), .id_rdst(id_rdst),
      .id_use_rsrc(id_use_rsrc), .id_use_rdst(id_use_rdst),
      .id_is_ret(id_is_ret), .ex_mem_read(ex_mem_read), .ex_rdst(ex_rdst),
      .ex_branch_taken(ex_branch_taken), .ret_pc_valid(ret_pc_valid),
      .IF_Stall(IF_Stall), .IF_Flush(IF_Flush), .id_bubble(id_bubble),
      .pc_hold(pc_hold), .ret_timeout(ret_timeout), .stall_count(stall_count),
      .dbg_state(dbg_state)
   );

   int errors = 0;
   int checks = 0;

   // Reference model state
   bit m_ret;
   int m_wait;
   bit m_to;
   int m_cnt;
   int obs_flush, obs_hold;

   typedef struct {
      logic [RW-1:0] rsrc;
      logic [RW-1:0] rdst;
      bit            use_rsrc;
      bit            use_rdst;
      bit            is_ret;
      bit            mem_read;
      logic [RW-1:0] exrd;
      bit            br;
      bit            e_stall;
      bit            e_flush;
      bit            e_bubble;
      bit            e_hold;
   } vec_t;

   vec_t vecs[10];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic set_in(input logic [RW-1:0] rs, input logic [RW-1:0] rd,
                         input bit urs, input bit urd, input bit ret, input bit mr,
                         input logic [RW-1:0] exrd, input bit br, input bit pcv);
      id_rsrc = rs; id_rdst = rd; id_use_rsrc = urs; id_use_rdst = urd;
      id_is_ret = ret; ex_mem_read = mr; ex_rdst = exrd;
      ex_branch_taken = br; ret_pc_valid = pcv;
   endtask

   // One clock cycle: compare DUT against the model, then advance the model.
   // Called at a negedge with inputs already applied.
   task automatic cycle();
      bit lu, e_st, e_fl, e_bu, e_ho;
      #2;
      lu = ex_mem_read && ((id_use_rsrc && id_rsrc == ex_rdst) ||
                           (id_use_rdst && id_rdst == ex_rdst));
      e_st = 0; e_fl = 0; e_bu = 0; e_ho = 0;
      if (!rst) begin
         if (!m_ret) begin
            if (ex_branch_taken) begin e_fl = 1; e_bu = 1; end
            else if (lu)         begin e_st = 1; e_ho = 1; e_bu = 1; end
            else if (id_is_ret)  begin e_fl = 1; e_ho = 1; end
         end else begin
            e_fl = 1;
            e_ho = !ret_pc_valid;
         end
      end
      chk("IF_Stall", 32'(IF_Stall), 32'(e_st));
      chk("IF_Flush", 32'(IF_Flush), 32'(e_fl));
      chk("id_bubble", 32'(id_bubble), 32'(e_bu));
      chk("pc_hold", 32'(pc_hold), 32'(e_ho));
      chk("stall_flush_excl", 32'(IF_Stall & IF_Flush), 32'd0);
      chk("ret_timeout", 32'(ret_timeout), 32'(m_to));
      chk("stall_count", 32'(stall_count), 32'(m_cnt));
      chk("state", 32'(dbg_state), 32'(m_ret));
      obs_flush += int'(IF_Flush);
      obs_hold  += int'(pc_hold);
      @(posedge clk);
      if (rst) begin
         m_ret = 0; m_wait = 0; m_to = 0; m_cnt = 0;
      end else begin
         if (e_st && m_cnt < CMAX) m_cnt++;
         if (!m_ret) begin
            if (!ex_branch_taken && !lu && id_is_ret) begin m_ret = 1; m_wait = 0; end
         end else if (ret_pc_valid) begin
            m_ret = 0;
         end else begin
            if (m_wait < MAXW) m_wait++;
            if (m_wait == MAXW) m_to = 1;
         end
      end
      @(negedge clk);
   endtask

   task automatic idle();
      set_in(3'd0, 3'd0, 0, 0, 0, 0, 3'd0, 0, 0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      idle();
      cycle();
      rst = 1'b0;
   endtask

   initial begin
      // Vector table: single cycles applied from RUN
      vecs[0] = '{3'd3, 3'd0, 1'b1, 1'b0, 1'b0, 1'b1, 3'd3, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
      vecs[1] = '{3'd3, 3'd3, 1'b0, 1'b0, 1'b0, 1'b1, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[2] = '{3'd5, 3'd3, 1'b0, 1'b1, 1'b0, 1'b1, 3'd3, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
      vecs[3] = '{3'd3, 3'd3, 1'b1, 1'b1, 1'b1, 1'b1, 3'd3, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
      vecs[4] = '{3'd1, 3'd2, 1'b0, 1'b0, 1'b1, 1'b0, 3'd4, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
      vecs[5] = '{3'd0, 3'd6, 1'b1, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
      vecs[6] = '{3'd3, 3'd3, 1'b1, 1'b1, 1'b0, 1'b0, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[7] = '{3'd7, 3'd1, 1'b1, 1'b0, 1'b1, 1'b1, 3'd7, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
      vecs[8] = '{3'd2, 3'd4, 1'b1, 1'b1, 1'b0, 1'b1, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[9] = '{3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

      // Power-up reset
      rst = 1'b1;
      idle();
      @(posedge clk);
      @(negedge clk);
      m_ret = 0; m_wait = 0; m_to = 0; m_cnt = 0;
      cycle();
      rst = 1'b0;

      // Table-driven vectors
      for (int i = 0; i < 10; i++) begin
         set_in(vecs[i].rsrc, vecs[i].rdst, vecs[i].use_rsrc, vecs[i].use_rdst,
                vecs[i].is_ret, vecs[i].mem_read, vecs[i].exrd, vecs[i].br, 1'b0);
         #1;
         chk($sformatf("vec%0d_stall", i), 32'(IF_Stall), 32'(vecs[i].e_stall));
         chk($sformatf("vec%0d_flush", i), 32'(IF_Flush), 32'(vecs[i].e_flush));
         chk($sformatf("vec%0d_bubble", i), 32'(id_bubble), 32'(vecs[i].e_bubble));
         chk($sformatf("vec%0d_hold", i), 32'(pc_hold), 32'(vecs[i].e_hold));
         cycle();
         do_reset();
      end

      // Load-use for one cycle, then the load leaves EX
      set_in(3'd3, 3'd0, 1, 0, 0, 1, 3'd3, 0, 0);
      cycle();
      ex_mem_read = 1'b0;
      cycle();
      chk("lu_stall_count", 32'(stall_count), 32'd1);

      // RET with popped PC on the third RET_WAIT cycle
      do_reset();
      obs_flush = 0; obs_hold = 0;
      set_in(3'd0, 3'd0, 0, 0, 1, 0, 3'd0, 0, 0);
      cycle();
      idle();
      cycle();
      cycle();
      ret_pc_valid = 1'b1;
      cycle();
      idle();
      chk("ret_flush_cycles", 32'(obs_flush), 32'd4);
      chk("ret_hold_cycles", 32'(obs_hold), 32'd3);
      chk("ret_back_in_run", 32'(dbg_state), 32'd0);
      chk("ret_no_timeout", 32'(ret_timeout), 32'd0);
      cycle();

      // RET timeout, then reset from inside RET_WAIT
      do_reset();
      set_in(3'd0, 3'd0, 0, 0, 1, 0, 3'd0, 0, 0);
      cycle();
      idle();
      for (int i = 1; i <= 6; i++) begin
         cycle();
         if (i == 3) chk("timeout_not_yet", 32'(ret_timeout), 32'd0);
         if (i == 4) chk("timeout_at_limit", 32'(ret_timeout), 32'd1);
      end
      chk("timeout_sticky", 32'(ret_timeout), 32'd1);
      do_reset();
      chk("timeout_cleared", 32'(ret_timeout), 32'd0);
      chk("reset_to_run", 32'(dbg_state), 32'd0);
      cycle();

      // Randomized stimulus against the model
      for (int n = 0; n < 3000; n++) begin
         rst = ($urandom_range(0, 63) == 0);
         set_in(3'($urandom_range(0, 3)), 3'($urandom_range(0, 3)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                ($urandom_range(0, 5) == 0), 1'($urandom_range(0, 1)),
                3'($urandom_range(0, 3)), ($urandom_range(0, 7) == 0),
                ($urandom_range(0, 3) == 0));
         cycle();
      end
      rst = 1'b0;

      // Continuous load-use: counter must saturate, not wrap
      do_reset();
      set_in(3'd2, 3'd0, 1, 0, 0, 1, 3'd2, 0, 0);
      for (int i = 0; i < CMAX + 6; i++) @(posedge clk);
      @(negedge clk);
      m_cnt = CMAX;
      chk("stall_count_saturated", 32'(stall_count), 32'hFFFF);
      cycle();
      cycle();
      idle();
      cycle();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
